// File: rtl/run_timer.sv
// BCD run timer: prescaled up/down count with saturation, sticky expiry and optional best-time capture.
// Best-time register is built only when RUN_TIMER_BEST_EN is defined.
module run_timer #(
  parameter int unsigned DIGITS     = 7,
  parameter int unsigned TICK_DIV   = 65_000_000,
  parameter int unsigned COUNT_DOWN = 0
) (
  input  logic                  system_clock_in,
  input  logic                  rst_n_in,
  input  logic                  clear_in,
  input  logic                  playing_in,
  input  logic                  load_in,
  input  logic [4*DIGITS-1:0]   load_val_in,
  input  logic                  game_over_in,
  output logic [4*DIGITS-1:0]   value_out,
  output logic                  tick_out,
  output logic                  expired_out,
  output logic [4*DIGITS-1:0]   best_out,
  output logic                  best_valid_out
);

  localparam int unsigned   W       = 4 * DIGITS;
  localparam int unsigned   PW      = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [W-1:0]  LIMIT   = (COUNT_DOWN != 0) ? '0 : {DIGITS{4'h9}};

  logic [PW-1:0] pre_q, pre_d;
  logic [W-1:0]  value_q, value_d;
  logic          tick_q, tick_d;
  logic          expired_q, expired_d;

  logic [W-1:0]  stepped;
  logic [W-1:0]  load_sat;
  logic [3:0]    step_digit;
  logic          carry;

  // Single-cycle ripple across all digits; carry doubles as borrow in down mode.
  always_comb begin
    stepped    = value_q;
    carry      = 1'b1;
    step_digit = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      step_digit = value_q[4*i +: 4];
      if (carry) begin
        if (COUNT_DOWN != 0) begin
          if (step_digit == 4'd0) step_digit = 4'd9;
          else begin
            step_digit = step_digit - 4'd1;
            carry      = 1'b0;
          end
        end else begin
          if (step_digit == 4'd9) step_digit = 4'd0;
          else begin
            step_digit = step_digit + 4'd1;
            carry      = 1'b0;
          end
        end
      end
      stepped[4*i +: 4] = step_digit;
    end
  end

  always_comb begin
    load_sat = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      load_sat[4*i +: 4] = (load_val_in[4*i +: 4] > 4'd9) ? 4'd9 : load_val_in[4*i +: 4];
    end
  end

  always_comb begin
    pre_d     = pre_q;
    value_d   = value_q;
    expired_d = expired_q;
    tick_d    = 1'b0;
    if (clear_in) begin
      pre_d     = '0;
      value_d   = '0;
      expired_d = 1'b0;
    end else if (load_in) begin
      pre_d     = '0;
      value_d   = load_sat;
      expired_d = (COUNT_DOWN != 0) && (load_sat == '0);
    end else if (playing_in) begin
      if (pre_q == PRE_MAX) begin
        pre_d  = '0;
        tick_d = 1'b1;
        // Prescaler keeps ticking past expiry; only the value saturates.
        if (value_q != LIMIT) begin
          value_d = stepped;
          if (stepped == LIMIT) expired_d = 1'b1;
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge system_clock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pre_q     <= '0;
      value_q   <= '0;
      tick_q    <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      value_q   <= value_d;
      tick_q    <= tick_d;
      expired_q <= expired_d;
    end
  end

  assign value_out   = value_q;
  assign tick_out    = tick_q;
  assign expired_out = expired_q;

`ifdef RUN_TIMER_BEST_EN
  logic [W-1:0] best_q, best_d;
  logic         best_valid_q, best_valid_d;

  // Captures the pre-update value, so a coincident clear/load/step does not affect it.
  always_comb begin
    best_d       = best_q;
    best_valid_d = best_valid_q;
    if (game_over_in && (!best_valid_q || (value_q > best_q))) begin
      best_d       = value_q;
      best_valid_d = 1'b1;
    end
  end

  always_ff @(posedge system_clock_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      best_q       <= '0;
      best_valid_q <= 1'b0;
    end else begin
      best_q       <= best_d;
      best_valid_q <= best_valid_d;
    end
  end

  assign best_out       = best_q;
  assign best_valid_out = best_valid_q;
`else
  logic unused_game_over;
  assign unused_game_over = game_over_in;
  assign best_out         = '0;
  assign best_valid_out   = 1'b0;
`endif

endmodule

// File: tb/tb_run_timer.sv
// Self-checking bench for run_timer: an up and a down instance (DIGITS=2, TICK_DIV=4)
// share stimulus and are compared each cycle against an integer-level reference model.
module tb_run_timer;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       playing;
  logic       load;
  logic [7:0] load_val;
  logic       game_over;

  logic [7:0] up_value, dn_value, up_best, dn_best;
  logic       up_tick, dn_tick, up_exp, dn_exp, up_bval, dn_bval;

  int checks   = 0;
  int failures = 0;

  int m_val [2];
  int m_pre [2];
  int m_bst [2];
  bit m_exp [2];
  bit m_tick[2];
  bit m_bval[2];

  run_timer #(.DIGITS(2), .TICK_DIV(4), .COUNT_DOWN(0)) u_up (
    .system_clock_in(clk), .rst_n_in(rst_n), .clear_in(clear), .playing_in(playing),
    .load_in(load), .load_val_in(load_val), .game_over_in(game_over),
    .value_out(up_value), .tick_out(up_tick), .expired_out(up_exp),
    .best_out(up_best), .best_valid_out(up_bval)
  );

  run_timer #(.DIGITS(2), .TICK_DIV(4), .COUNT_DOWN(1)) u_dn (
    .system_clock_in(clk), .rst_n_in(rst_n), .clear_in(clear), .playing_in(playing),
    .load_in(load), .load_val_in(load_val), .game_over_in(game_over),
    .value_out(dn_value), .tick_out(dn_tick), .expired_out(dn_exp),
    .best_out(dn_best), .best_valid_out(dn_bval)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic int sat_dec(input logic [7:0] b);
    int tens;
    int units;
    tens  = (b[7:4] > 4'd9) ? 9 : int'(b[7:4]);
    units = (b[3:0] > 4'd9) ? 9 : int'(b[3:0]);
    return tens * 10 + units;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_val[m] = 0; m_pre[m] = 0; m_bst[m] = 0;
      m_exp[m] = 0; m_tick[m] = 0; m_bval[m] = 0;
    end
  endtask

  // One clock edge of behaviour, using the inputs present at that edge.
  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
`ifdef RUN_TIMER_BEST_EN
      if (game_over && (!m_bval[m] || m_val[m] > m_bst[m])) begin
        m_bst[m]  = m_val[m];
        m_bval[m] = 1;
      end
`endif
      m_tick[m] = 0;
      if (clear) begin
        m_val[m] = 0; m_pre[m] = 0; m_exp[m] = 0;
      end else if (load) begin
        m_val[m] = sat_dec(load_val);
        m_pre[m] = 0;
        m_exp[m] = (m == 1) && (m_val[m] == 0);
      end else if (playing) begin
        m_pre[m] = (m_pre[m] + 1) % 4;
        if (m_pre[m] == 0) begin
          m_tick[m] = 1;
          if (m == 0 && m_val[m] < 99) begin
            m_val[m]++;
            if (m_val[m] == 99) m_exp[m] = 1;
          end else if (m == 1 && m_val[m] > 0) begin
            m_val[m]--;
            if (m_val[m] == 0) m_exp[m] = 1;
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    check("up_value", up_value, to_bcd(m_val[0]));
    check("up_tick", {7'd0, up_tick}, {7'd0, m_tick[0]});
    check("up_expired", {7'd0, up_exp}, {7'd0, m_exp[0]});
    check("up_best", up_best, to_bcd(m_bst[0]));
    check("up_best_valid", {7'd0, up_bval}, {7'd0, m_bval[0]});
    check("dn_value", dn_value, to_bcd(m_val[1]));
    check("dn_tick", {7'd0, dn_tick}, {7'd0, m_tick[1]});
    check("dn_expired", {7'd0, dn_exp}, {7'd0, m_exp[1]});
    check("dn_best", dn_best, to_bcd(m_bst[1]));
    check("dn_best_valid", {7'd0, dn_bval}, {7'd0, m_bval[1]});
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic pulse_load(input logic [7:0] v);
    load = 1'b1; load_val = v;
    cycle();
    load = 1'b0;
  endtask

  int ticks_seen;

  initial begin
    rst_n = 1'b0; clear = 1'b0; playing = 1'b0; load = 1'b0;
    load_val = '0; game_over = 1'b0;
    model_reset();
    #2;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // Free run from reset: tick every 4th cycle, up count reaches 10.
    playing = 1'b1;
    run(40);
    check("up_after_40", up_value, 8'h10);
    playing = 1'b0;

    // Saturation at 99 with ticks continuing.
    pulse_load(8'h97);
    playing = 1'b1;
    run(12);
    check("up_sat_99", up_value, 8'h99);
    check("up_sat_exp", {7'd0, up_exp}, 8'd1);
    playing = 1'b0;

    // Down count from 10 to 0, then out-of-range digit load and zero load.
    pulse_load(8'h10);
    playing = 1'b1;
    run(48);
    check("dn_reach_0", dn_value, 8'h00);
    check("dn_exp_0", {7'd0, dn_exp}, 8'd1);
    playing = 1'b0;
    pulse_load(8'h0A);
    check("dn_load_0A", dn_value, 8'h09);
    check("dn_load_0A_exp", {7'd0, dn_exp}, 8'd0);
    pulse_load(8'h00);
    check("dn_load_zero_exp", {7'd0, dn_exp}, 8'd1);

    // Pause keeps the fractional prescaler count.
    clear = 1'b1; cycle(); clear = 1'b0;
    ticks_seen = 0;
    playing = 1'b1;
    repeat (2) begin cycle(); ticks_seen += int'(up_tick); end
    playing = 1'b0;
    repeat (50) begin cycle(); ticks_seen += int'(up_tick); end
    playing = 1'b1;
    repeat (2) begin cycle(); ticks_seen += int'(up_tick); end
    playing = 1'b0;
    check("pause_ticks", 8'(ticks_seen), 8'd1);
    check("pause_value", up_value, 8'h01);

    // Best-time capture sequence.
    clear = 1'b1; cycle(); clear = 1'b0;
    playing = 1'b1; run(20); playing = 1'b0;
    game_over = 1'b1; cycle(); game_over = 1'b0;
    clear = 1'b1; cycle(); clear = 1'b0;
    playing = 1'b1; run(12); playing = 1'b0;
    game_over = 1'b1; cycle(); game_over = 1'b0;
`ifdef RUN_TIMER_BEST_EN
    check("best_keeps_05", up_best, 8'h05);
`endif
    playing = 1'b1; run(16); playing = 1'b0;
    game_over = 1'b1; cycle(); game_over = 1'b0;
`ifdef RUN_TIMER_BEST_EN
    check("best_takes_07", up_best, 8'h07);
`endif

    // Asynchronous reset mid-count at prescaler 2, value 42.
    pulse_load(8'h42);
    playing = 1'b1;
    run(2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 rst_n = 1'b1;
    run(3);
    check("rst_no_early_tick", {7'd0, up_tick}, 8'd0);
    cycle();
    check("rst_first_tick", {7'd0, up_tick}, 8'd1);
    check("rst_first_value", up_value, 8'h01);

    // Randomised traffic, including coincident strobes.
    for (int i = 0; i < 600; i++) begin
      clear     = ($urandom_range(0, 31) == 0);
      load      = ($urandom_range(0, 15) == 0);
      load_val  = 8'($urandom);
      playing   = ($urandom_range(0, 3) != 0);
      game_over = ($urandom_range(0, 11) == 0);
      cycle();
    end
    clear = 1'b0; load = 1'b0; playing = 1'b0; game_over = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_timer.md
RUN_TIMER -- requirements
Module: run_timer

Interface
REQ-001 The module SHALL have parameter DIGITS, default 7, meaning the number of BCD digits held (legal range 1..8).
REQ-002 The module SHALL have parameter TICK_DIV, default 65_000_000, meaning the number of clock cycles per count step (legal range 2 or more).
REQ-003 The module SHALL have parameter COUNT_DOWN, default 0, meaning 0 = count up and 1 = count down.
REQ-004 The module SHALL have port system_clock_in, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst_n_in, input, 1 bit, an asynchronous active-low reset.
REQ-006 The module SHALL have port clear_in, input, 1 bit, a synchronous clear pulse.
REQ-007 The module SHALL have port playing_in, input, 1 bit, count enable (level).
REQ-008 The module SHALL have port load_in, input, 1 bit, a synchronous preset strobe.
REQ-009 The module SHALL have port load_val_in, input, 4*DIGITS bits, the BCD preset value.
REQ-010 The module SHALL have port game_over_in, input, 1 bit, a best-time capture strobe.
REQ-011 The module SHALL have port value_out, output, 4*DIGITS bits, the current BCD count with digit 0 in bits [3:0].
REQ-012 The module SHALL have port tick_out, output, 1 bit, a one-cycle pulse on each count step.
REQ-013 The module SHALL have port expired_out, output, 1 bit, a sticky limit-reached flag.
REQ-014 The module SHALL have port best_out, output, 4*DIGITS bits, the best BCD value captured.
REQ-015 The module SHALL have port best_valid_out, output, 1 bit, which is high once best_out holds a capture.

Function
REQ-016 The prescaler SHALL be ceil(log2(TICK_DIV)) bits wide and SHALL increment only in cycles with playing_in=1 and no clear_in or load_in.
REQ-017 When the prescaler equals TICK_DIV-1 and it advances, it SHALL wrap to 0, and tick_out SHALL be 1 in the following cycle.
REQ-018 The value_out update SHALL become visible in that same cycle as tick_out.
REQ-019 With playing_in=0, the prescaler and value_out SHALL hold, giving pause/resume without losing the fractional count.
REQ-020 In up mode, each step SHALL add 1 in BCD with ripple carry across all digits in a single cycle (for example 0199 becomes 0200).
REQ-021 In up mode, when value_out is all 9s it SHALL hold, and expired_out SHALL set on the step that produces all 9s.
REQ-022 In down mode, each step SHALL subtract 1 in BCD with borrow (for example 0200 becomes 0199).
REQ-023 In down mode, value_out SHALL hold at 0, and expired_out SHALL set on the step that produces 0.
REQ-024 The prescaler and tick_out SHALL keep running after expiry while playing_in=1; only value_out saturates.
REQ-025 clear_in SHALL take priority over load_in, which SHALL take priority over a step.
REQ-026 clear_in SHALL set value_out=0, prescaler=0 and expired_out=0 in the next cycle, with no tick_out in that cycle.
REQ-027 load_in SHALL set value_out=load_val_in, prescaler=0 and expired_out=0.
REQ-028 During load_in, any load digit above 9 SHALL be stored as 9.
REQ-029 In down mode, a load of 0 SHALL set expired_out=1.
REQ-030 On game_over_in, best_out SHALL capture the value_out present in that cycle (pre-step if a step coincides) when best_valid_out=0 or that value exceeds best_out.
REQ-031 A capture SHALL set best_valid_out=1.
REQ-032 An equal or lower value SHALL leave best_out unchanged.
REQ-033 clear_in and load_in SHALL NOT alter best_out or best_valid_out.
REQ-034 If game_over_in coincides with clear_in or load_in, the capture SHALL use the pre-clear/pre-load value.

Reset
REQ-035 rst_n_in=0 SHALL immediately force value_out=0, prescaler=0, tick_out=0, expired_out=0, best_out=0 and best_valid_out=0, independent of the clock.
REQ-036 Reset asserted mid-count SHALL discard the fractional prescaler count; counting SHALL restart from the first clock edge after release.

Configuration
REQ-037 Macro RUN_TIMER_BEST_EN SHALL control the best-time logic.
REQ-038 With RUN_TIMER_BEST_EN defined, REQ-030 to REQ-034 SHALL apply.
REQ-039 With RUN_TIMER_BEST_EN undefined, no best register SHALL be built, best_out SHALL be tied to 0, best_valid_out SHALL be tied to 0, and game_over_in SHALL be ignored.

Verification (DIGITS=2, TICK_DIV=4 unless stated)
REQ-040 Up mode: reset, playing=1 for 40 cycles -> tick_out every 4th cycle; value_out 00,01,...,10 with carry at 09 to 10.
REQ-041 Up mode: load 97, play 12 cycles -> 98, 99, then hold at 99; expired_out=1 from the step producing 99; tick_out continues.
REQ-042 Down mode (COUNT_DOWN=1): load 10, play -> 09 after the first tick, then down to 00 with expired_out=1; load 0A -> value 09 and expired_out=0.
REQ-043 Pause: play 2 cycles, playing=0 for 50 cycles, play 2 cycles -> exactly one tick total; value_out=01.
REQ-044 Best (RUN_TIMER_BEST_EN): reach 05, game_over -> best 05 valid; clear, reach 03, game_over -> best stays 05; reach 07, game_over -> best 07.
REQ-045 Async reset mid-count at prescaler=2, value 42 -> all outputs 0 before the next edge; first tick 4 cycles after release.
